mips_instr_encoder_loader: RTL and testbench

- Hardware encoder for the MIPS instruction set: the inverse of the opcode decoder.
- Accepts symbolic instruction requests (class plus register/immediate fields) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and writes it sequentially into instruction memory.
- Sits between the bench/boot source and the instruction memory; used to load programs before the core runs.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mips_instr_packer.sv | 47 ++++
 rtl/mips_instr_encoder_loader.sv | 157 +++++++++++++++
 tb/tb_mips_instr_encoder_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, the symbolic instruction class
// and the encoder/loader state encoding. The opcode constants are also used
// by the instruction decoder, so the two ends stay in step.
package mips_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_LW    = 3'd1,
    CLS_SW    = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_J     = 3'd4
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

endpackage

// File: rtl/mips_instr_packer.sv
// Combinational MIPS instruction packer.
// Ports:
//   cls                               instruction class (see instr_class_e)
//   rs, rt, rd, shamt, funct, imm,
//   target                            raw instruction fields, passed unmodified
//   word                              packed 32-bit instruction (0 when illegal)
//   illegal                           class is not encodable in this build
// Build option: MIPS_ENC_JUMP_EN enables the J class; without it class 4 is
// reported as illegal.
module mips_instr_packer
  import mips_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

`ifndef MIPS_ENC_JUMP_EN
  // The jump target has no consumer when jumps are not encodable.
  logic unused_target_s;
  assign unused_target_s = ^target;
`endif

  // Select the instruction layout from the class.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (cls)
      CLS_RTYPE: word = {OPC_RTYPE, rs, rt, rd, shamt, funct};
      CLS_LW:    word = {OPC_LW, rs, rt, imm};
      CLS_SW:    word = {OPC_SW, rs, rt, imm};
      CLS_BEQ:   word = {OPC_BEQ, rs, rt, imm};
`ifdef MIPS_ENC_JUMP_EN
      CLS_J:     word = {OPC_J, target};
`endif
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder_loader.sv
// MIPS instruction encoder/loader: accepts symbolic instruction requests over
// a valid/ready handshake, packs them into 32-bit words and writes them to
// consecutive instruction-memory word addresses starting at BASE_ADDR.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             open a load session (only in IDLE)
//   in_valid/in_ready request handshake; in_class + field inputs; in_last
//   mem_we/addr/wdata instruction-memory write port (held when mem_we=0)
//   busy, done, err   status: not idle, end-of-session pulse, sticky error
//   word_count        words written in the current session
// Build option: MIPS_ENC_JUMP_EN (see mips_instr_packer) enables the J class.
module mips_instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int unsigned           ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  enc_state_e        state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic              full_r;
  logic              last_r;
  logic [31:0]       word_s;
  logic              illegal_s;
  logic              hs_s;
  logic              drop_s;
  logic              in_ready_nxt_s, busy_nxt_s, done_nxt_s, mem_we_nxt_s;

  mips_instr_packer u_packer (
    .cls     (in_class),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word_s),
    .illegal (illegal_s)
  );

  // in_ready is a registered copy of "state is ACCEPT", so the handshake can
  // be qualified directly by the state.
  assign hs_s   = (state_r == ST_ACCEPT) && in_valid;
  // Once the top address has been written the memory is full; further
  // requests are dropped so the wrap never lands on BASE_ADDR again.
  assign drop_s = hs_s && (illegal_s || full_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_ACCEPT;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ACCEPT: begin
        if (hs_s) begin
          if (drop_s) state_nxt_s = in_last ? ST_DONE : ST_ACCEPT;
          else        state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_ACCEPT;
        end
      end
      ST_WRITE: state_nxt_s = last_r ? ST_DONE : ST_ACCEPT;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Status outputs are derived from the next state so the registered copies
  // line up with the state they describe.
  always_comb begin
    in_ready_nxt_s = (state_nxt_s == ST_ACCEPT);
    busy_nxt_s     = (state_nxt_s != ST_IDLE);
    done_nxt_s     = (state_nxt_s == ST_DONE);
    mem_we_nxt_s   = (state_nxt_s == ST_WRITE);
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      in_ready <= in_ready_nxt_s;
      busy     <= busy_nxt_s;
      done     <= done_nxt_s;
      mem_we   <= mem_we_nxt_s;
    end
  end

  // Session datapath: address counter, full flag, sticky error, word count
  // and the write-port registers (loaded only for accepted legal requests).
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= BASE_ADDR;
      full_r     <= 1'b0;
      last_r     <= 1'b0;
      err        <= 1'b0;
      word_count <= {(ADDR_W+1){1'b0}};
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= 32'h0000_0000;
    end else if ((state_r == ST_IDLE) && start) begin
      addr_r     <= BASE_ADDR;
      full_r     <= 1'b0;
      err        <= 1'b0;
      word_count <= {(ADDR_W+1){1'b0}};
    end else if (hs_s) begin
      last_r <= in_last;
      if (drop_s) begin
        err <= 1'b1;
      end else begin
        mem_addr  <= addr_r;
        mem_wdata <= word_s;
      end
    end else if (state_r == ST_WRITE) begin
      addr_r     <= addr_r + ADDR_W'(1);
      word_count <= word_count + (ADDR_W+1)'(1);
      if (addr_r == {ADDR_W{1'b1}}) full_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder_loader.sv
// Directed self-checking bench for mips_instr_encoder_loader. A second
// instance with ADDR_W=2 exercises the full/wrap behaviour.
module tb_mips_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, start2, in_valid, in_last;
  logic [2:0]  in_class;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  word_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_instr_encoder_loader #(.ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .word_count(word_count)
  );

  mips_instr_encoder_loader #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2), .done(done2),
    .err(err2), .word_count(word_count2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; sample #1 after that edge.
  task automatic send(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    in_class = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic open1();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int exp_a;

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_class = 3'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
    in_funct = 6'd0; in_imm = 16'd0; in_target = 26'd0;
    tick(); tick();
    chk("rst_we",    {63'd0, mem_we}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_wc",    {55'd0, word_count}, 64'd0);
    rst = 1'b0;
    tick();

    // Single RTYPE session.
    open1();
    chk("s1_ready", {63'd0, in_ready}, 64'd1);
    chk("s1_busy",  {63'd0, busy}, 64'd1);
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'd0, 26'd0, 1'b1);
    chk("s1_we",    {63'd0, mem_we}, 64'd1);
    chk("s1_addr",  {56'd0, mem_addr}, 64'd0);
    chk("s1_wdata", {32'd0, mem_wdata}, 64'h0000_0000_0022_1820);
    chk("s1_ready_w", {63'd0, in_ready}, 64'd0);
    tick();
    chk("s1_done",  {63'd0, done}, 64'd1);
    chk("s1_we_off", {63'd0, mem_we}, 64'd0);
    chk("s1_wc",    {55'd0, word_count}, 64'd1);
    chk("s1_hold",  {32'd0, mem_wdata}, 64'h0000_0000_0022_1820);
    tick();
    chk("s1_idle_done", {63'd0, done}, 64'd0);
    chk("s1_idle_busy", {63'd0, busy}, 64'd0);

    // LW / SW / BEQ session.
    open1();
    send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
    chk("lw_we",    {63'd0, mem_we}, 64'd1);
    chk("lw_addr",  {56'd0, mem_addr}, 64'd0);
    chk("lw_wdata", {32'd0, mem_wdata}, 64'h0000_0000_8D28_0004);
    tick();
    send(3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
    chk("sw_addr",  {56'd0, mem_addr}, 64'd1);
    chk("sw_wdata", {32'd0, mem_wdata}, 64'h0000_0000_AD28_0004);
    tick();
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1);
    chk("beq_we",    {63'd0, mem_we}, 64'd1);
    chk("beq_addr",  {56'd0, mem_addr}, 64'd2);
    chk("beq_wdata", {32'd0, mem_wdata}, 64'h0000_0000_1022_FFFF);
    tick();
    chk("s2_done", {63'd0, done}, 64'd1);
    chk("s2_err",  {63'd0, err}, 64'd0);
    chk("s2_wc",   {55'd0, word_count}, 64'd3);
    tick();

    // Jump, illegal class, sticky error.
    open1();
    send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0100, 1'b0);
`ifdef MIPS_ENC_JUMP_EN
    chk("j_we",    {63'd0, mem_we}, 64'd1);
    chk("j_wdata", {32'd0, mem_wdata}, 64'h0000_0000_0800_0100);
    chk("j_err",   {63'd0, err}, 64'd0);
    tick();
    exp_a = 1;
`else
    chk("j_we",    {63'd0, mem_we}, 64'd0);
    chk("j_err",   {63'd0, err}, 64'd1);
    chk("j_ready", {63'd0, in_ready}, 64'd1);
    exp_a = 0;
`endif
    send(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0);
    chk("ill_we",    {63'd0, mem_we}, 64'd0);
    chk("ill_err",   {63'd0, err}, 64'd1);
    chk("ill_ready", {63'd0, in_ready}, 64'd1);
    send(3'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'b000000, 16'd0, 26'd0, 1'b0);
    chk("after_ill_we",   {63'd0, mem_we}, 64'd1);
    chk("after_ill_addr", {56'd0, mem_addr}, 64'(exp_a));
    chk("after_ill_wd",   {32'd0, mem_wdata}, 64'h0000_0000_0085_3080);
    chk("err_sticky",     {63'd0, err}, 64'd1);
    tick();
    send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    chk("ill_last_done", {63'd0, done}, 64'd1);
    chk("ill_last_we",   {63'd0, mem_we}, 64'd0);
    chk("ill_last_addr", {56'd0, mem_addr}, 64'(exp_a));
    tick();
    chk("err_idle", {63'd0, err}, 64'd1);
    open1();
    chk("err_clr",  {63'd0, err}, 64'd0);
    chk("wc_clr",   {55'd0, word_count}, 64'd0);

    // Start while busy is ignored; the session keeps counting.
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'd0, 26'd0, 1'b0);
    chk("sb_addr0", {56'd0, mem_addr}, 64'd0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_wc",    {55'd0, word_count}, 64'd1);
    chk("sb_ready", {63'd0, in_ready}, 64'd1);
    send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
    chk("sb_addr1", {56'd0, mem_addr}, 64'd1);
    chk("sb_we",    {63'd0, mem_we}, 64'd1);

    // Reset asserted during the WRITE cycle clears everything.
    rst = 1'b1;
    tick();
    chk("rw_we",    {63'd0, mem_we}, 64'd0);
    chk("rw_addr",  {56'd0, mem_addr}, 64'd0);
    chk("rw_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rw_busy",  {63'd0, busy}, 64'd0);
    chk("rw_wc",    {55'd0, word_count}, 64'd0);
    rst = 1'b0;
    tick();

    // Reset together with a handshake: no write is issued.
    open1();
    rst = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'd0, 26'd0, 1'b1);
    chk("rh_we",    {63'd0, mem_we}, 64'd0);
    chk("rh_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    tick();

    // ADDR_W=2: four writes fill the memory, the fifth is dropped.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 5'd0, 5'd0, 5'(i), 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
      chk("full_we",    {63'd0, mem_we2}, 64'd1);
      chk("full_addr",  {62'd0, mem_addr2}, 64'(i));
      chk("full_wdata", {32'd0, mem_wdata2}, 64'(i << 11));
      tick();
    end
    send(3'd0, 5'd0, 5'd0, 5'd7, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    chk("full5_we",   {63'd0, mem_we2}, 64'd0);
    chk("full5_err",  {63'd0, err2}, 64'd1);
    chk("full5_done", {63'd0, done2}, 64'd1);
    chk("full5_wc",   {61'd0, word_count2}, 64'd4);
    chk("full5_addr", {62'd0, mem_addr2}, 64'd3);
    chk("dut1_quiet", {63'd0, mem_we}, 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
